// File: rtl/cache_pkg.sv
// Shared types and address helpers for the set-associative instruction cache.
// Build option: ICACHE_PERF_EN enables hit/miss counters in icache_assoc.
package cache_pkg;

    typedef enum logic {
        IDLE,
        FILL
    } icache_assoc_state_t;

    localparam logic [31:0] BAD_WORD = 32'hBAD0_BAD0;

    function automatic logic [31:0] addr_off(
        input logic [31:0] a,
        input int          off_w
    );
        return (a >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_idx(
        input logic [31:0] a,
        input int          off_w,
        input int          idx_w
    );
        return (a >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(
        input logic [31:0] a,
        input int          off_w,
        input int          idx_w
    );
        return a >> (2 + off_w + idx_w);
    endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU state for icache_assoc.
// Each set keeps WAYS-1 bits; every bit points toward the colder subtree.
module icache_plru
    import cache_pkg::*;
#(
    parameter  int SETS = 16,
    parameter  int WAYS = 2,
    localparam int IW   = $clog2(SETS),
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          touch_en,
    input  logic [IW-1:0] touch_set,
    input  logic [WW-1:0] touch_way,
    input  logic [IW-1:0] victim_set,
    output logic [WW-1:0] victim_way
);

    if (WAYS == 1) begin : g_direct
        logic unused_ok;
        assign unused_ok = ^{clk, rst, flush, touch_en,
                             touch_set, touch_way, victim_set};
        assign victim_way = '0;
    end else begin : g_tree
        localparam int PB = WAYS - 1;

        logic [PB-1:0] plru_q [SETS];
        logic [PB-1:0] plru_d [SETS];
        logic [PB-1:0] nxt;
        logic [PB-1:0] vb;

        assign vb = plru_q[victim_set];

        if (WAYS == 2) begin : g_w2
            always_comb begin
                nxt    = plru_q[touch_set];
                nxt[0] = ~touch_way[0];
            end
            assign victim_way = vb[0];
        end else begin : g_w4
            always_comb begin
                nxt    = plru_q[touch_set];
                nxt[0] = ~touch_way[1];
                if (touch_way[1]) nxt[2] = ~touch_way[0];
                else              nxt[1] = ~touch_way[0];
            end
            assign victim_way = vb[0] ? {1'b1, vb[2]} : {1'b0, vb[1]};
        end

        // flush has priority over a touch in the same cycle
        always_comb begin
            plru_d = plru_q;
            if (flush) begin
                for (int s = 0; s < SETS; s++) plru_d[s] = '0;
            end else if (touch_en) begin
                plru_d[touch_set] = nxt;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            end else begin
                plru_q <= plru_d;
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word block fill and flush.
// Build option: ICACHE_PERF_EN adds hit_cnt/miss_cnt counters (else tied 0).
module icache_assoc
    import cache_pkg::*;
#(
    parameter int SETS        = 16,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 2,
    parameter int CPUID       = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW    = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [31:0] BASE_MASK = 32'(BLOCK_WORDS * 4 - 1);

    typedef struct packed {
        logic                        valid;
        logic [TAG_W-1:0]            tag;
        logic [BLOCK_WORDS-1:0][31:0] data;
    } icache_frame_t;

    icache_frame_t frame_q [WAYS][SETS];
    icache_frame_t frame_d [WAYS][SETS];

    icache_assoc_state_t state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         base_q, base_d;
    logic [WW-1:0]       victim_q, victim_d;

    logic [IDX_W-1:0] req_idx, fill_idx, touch_set;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [CW-1:0]    req_off;
    logic             hit_any, inv_any, touch_en;
    logic [WW-1:0]    hit_way, inv_way, plru_way, vict_way, touch_way;
    logic             miss_go, accept, last;
    logic             unused_ok;

    assign unused_ok = ^{imemaddr[1:0], BAD_WORD, 32'(CPUID)};

    assign req_idx  = IDX_W'(addr_idx(imemaddr, OFF_W, IDX_W));
    assign req_tag  = TAG_W'(addr_tag(imemaddr, OFF_W, IDX_W));
    assign req_off  = CW'(addr_off(imemaddr, OFF_W));
    assign fill_idx = IDX_W'(addr_idx(base_q, OFF_W, IDX_W));
    assign fill_tag = TAG_W'(addr_tag(base_q, OFF_W, IDX_W));

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && frame_q[w][req_idx].valid &&
                frame_q[w][req_idx].tag == req_tag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
            if (!inv_any && !frame_q[w][req_idx].valid) begin
                inv_any = 1'b1;
                inv_way = WW'(w);
            end
        end
        vict_way = inv_any ? inv_way : plru_way;
    end

    assign ihit     = (state_q == IDLE) && imemREN && hit_any && !flush;
    assign miss_go  = (state_q == IDLE) && imemREN && !hit_any && !flush;
    assign imemload = ihit ? frame_q[hit_way][req_idx].data[req_off] : '0;

    assign accept = (state_q == FILL) && !iwait;
    assign last   = (cnt_q == CW'(BLOCK_WORDS - 1));
    assign iREN   = (state_q == FILL);
    assign iaddr  = iREN ? base_q + (32'(cnt_q) << 2) : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        victim_d  = victim_q;
        frame_d   = frame_q;
        touch_en  = 1'b0;
        touch_set = req_idx;
        touch_way = hit_way;
        unique case (state_q)
            IDLE: begin
                if (miss_go) begin
                    state_d  = FILL;
                    cnt_d    = '0;
                    base_d   = imemaddr & ~BASE_MASK;
                    victim_d = vict_way;
                end else if (ihit) begin
                    touch_en = 1'b1;
                end
            end
            FILL: begin
                if (accept) begin
                    frame_d[victim_q][fill_idx].data[cnt_q] = iload;
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
                        frame_d[victim_q][fill_idx].tag   = fill_tag;
                        frame_d[victim_q][fill_idx].valid = 1'b1;
                        touch_en  = 1'b1;
                        touch_set = fill_idx;
                        touch_way = victim_q;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: ;
        endcase
        // a partial or just-completed block is never left valid by a flush
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            touch_en = 1'b0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    frame_d[w][s].valid = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            victim_q <= '0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    frame_q[w][s] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            victim_q <= victim_d;
            frame_q  <= frame_d;
        end
    end

    icache_plru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_plru (
        .clk        (CLK),
        .rst        (RST),
        .flush      (flush),
        .touch_en   (touch_en),
        .touch_set  (touch_set),
        .touch_way  (touch_way),
        .victim_set (req_idx),
        .victim_way (plru_way)
    );

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + (ihit ? 32'd1 : 32'd0);
        miss_cnt_d = miss_cnt_q + (miss_go ? 32'd1 : 32'd0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed tables, hand sequences
// and a randomized phase against a set/LRU reference model.
module tb_icache_assoc;

`ifdef ICACHE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        imemREN, flush, iwait;
    logic [31:0] imemaddr;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, iload, hit_cnt, miss_cnt;

    logic        imemREN4, flush4, iwait4;
    logic [31:0] imemaddr4;
    logic        ihit4, iREN4;
    logic [31:0] imemload4, iaddr4, iload4, hit_cnt4, miss_cnt4;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h5A5A_C3C3;
    endfunction

    assign iload  = memf(iaddr);
    assign iload4 = memf(iaddr4);

    icache_assoc u_dut (
        .CLK(clk), .RST(rst), .imemREN(imemREN), .imemaddr(imemaddr),
        .flush(flush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
        .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    icache_assoc #(.SETS(16), .WAYS(2), .BLOCK_WORDS(4), .CPUID(1)) u_dut4 (
        .CLK(clk), .RST(rst), .imemREN(imemREN4), .imemaddr(imemaddr4),
        .flush(flush4), .ihit(ihit4), .imemload(imemload4), .iREN(iREN4),
        .iaddr(iaddr4), .iload(iload4), .iwait(iwait4),
        .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
    );

    int nchk = 0;
    int nerr = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // reference model: 2 ways per set, true LRU (equal to tree-PLRU here)
    bit          m_valid [16][2];
    logic [31:0] m_tag   [16][2];
    int          m_mru   [16];

    function automatic int m_set(input logic [31:0] a);
        return int'((a >> 3) & 32'hF);
    endfunction

    function automatic bit m_lookup(input logic [31:0] a, output int way);
        int s = m_set(a);
        way = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == (a >> 7)) begin
                way = w;
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < 16; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_mru[s] = 0;
        end
    endtask

    task automatic m_install(input logic [31:0] a);
        int s = m_set(a);
        int v;
        if (!m_valid[s][0])      v = 0;
        else if (!m_valid[s][1]) v = 1;
        else                     v = 1 - m_mru[s];
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = a >> 7;
        m_mru[s]      = v;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one lookup; on a miss, drive the fill to completion with wait pattern
    task automatic access(input logic [31:0] a, input bit exp_hit,
                          input int wmode);
        int k, cyc, wc, way;
        bit mh;
        logic [31:0] base;
        base = a & ~32'h7;
        imemREN = 1'b1;
        imemaddr = a;
        iwait = 1'b1;
        flush = 1'b0;
        mh = m_lookup(a, way);
        @(negedge clk);
        chk("ihit_lookup", 32'(ihit), 32'(exp_hit));
        if (exp_hit) begin
            chk("imemload_hit", imemload, memf(a & ~32'h3));
            exp_hits++;
            if (mh) m_mru[m_set(a)] = way;
            step();
        end else begin
            exp_misses++;
            step();
            k = 0;
            cyc = 0;
            wc = 0;
            while (k < 2 && cyc < 200) begin
                imemREN = 1'($urandom);
                imemaddr = $urandom;
                if (wmode < 0) iwait = 1'($urandom_range(0, 1));
                else           iwait = (wc < wmode);
                @(negedge clk);
                chk("iREN_fill", 32'(iREN), 32'd1);
                chk("iaddr_fill", iaddr, base + 32'(4 * k));
                chk("ihit_fill", 32'(ihit), 32'd0);
                if (!iwait) begin
                    k++;
                    wc = 0;
                end else begin
                    wc++;
                end
                step();
                cyc++;
            end
            if (k < 2) chk("fill_timeout", 32'(k), 32'd2);
            m_install(a);
            imemREN = 1'b0;
            iwait = 1'b1;
        end
    endtask

    task automatic do_flush(input logic [31:0] a);
        imemREN = 1'b1;
        imemaddr = a;
        flush = 1'b1;
        iwait = 1'b1;
        @(negedge clk);
        chk("ihit_flush_cycle", 32'(ihit), 32'd0);
        step();
        flush = 1'b0;
        imemREN = 1'b0;
        m_clear();
    endtask

    typedef struct {
        bit          fl;
        logic [31:0] addr;
        bit          hit;
    } vec_t;

    vec_t tbl  [11];
    vec_t ptbl [8];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h000, 1'b0};
        tbl[1]  = '{1'b0, 32'h100, 1'b0};
        tbl[2]  = '{1'b0, 32'h200, 1'b0};
        tbl[3]  = '{1'b0, 32'h100, 1'b1};
        tbl[4]  = '{1'b0, 32'h000, 1'b0};
        tbl[5]  = '{1'b1, 32'h000, 1'b0};
        tbl[6]  = '{1'b0, 32'h100, 1'b0};
        tbl[7]  = '{1'b0, 32'h000, 1'b1};
        tbl[8]  = '{1'b0, 32'h200, 1'b0};
        tbl[9]  = '{1'b0, 32'h004, 1'b1};
        tbl[10] = '{1'b0, 32'h100, 1'b0};
        ptbl[0] = '{1'b0, 32'h040, 1'b0};
        ptbl[1] = '{1'b0, 32'h040, 1'b1};
        ptbl[2] = '{1'b0, 32'h044, 1'b1};
        ptbl[3] = '{1'b0, 32'h000, 1'b0};
        ptbl[4] = '{1'b0, 32'h000, 1'b1};
        ptbl[5] = '{1'b0, 32'h104, 1'b0};
        ptbl[6] = '{1'b0, 32'h100, 1'b1};
        ptbl[7] = '{1'b0, 32'h104, 1'b1};

        imemREN = 0; imemaddr = 0; flush = 0; iwait = 1;
        imemREN4 = 0; imemaddr4 = 0; flush4 = 0; iwait4 = 1;
        m_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_iREN", 32'(iREN), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        step();
        rst = 1'b0;

        imemREN = 1'b0;
        imemaddr = 32'h40;
        @(negedge clk);
        chk("idle_ihit", 32'(ihit), 32'd0);
        chk("idle_imemload", imemload, 32'd0);
        step();

        access(32'h40, 1'b0, 2);
        access(32'h40, 1'b1, -1);
        access(32'h44, 1'b1, -1);

        foreach (tbl[i]) begin
            if (tbl[i].fl) do_flush(32'h40);
            access(tbl[i].addr, tbl[i].hit, -1);
        end

        do_flush(32'h0);
        imemREN = 1'b1;
        imemaddr = 32'h500;
        iwait = 1'b1;
        @(negedge clk);
        chk("fl_last_miss", 32'(ihit), 32'd0);
        exp_misses++;
        step();
        iwait = 1'b0;
        @(negedge clk);
        chk("fl_last_w0", iaddr, 32'h500);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_last_w1", iaddr, 32'h504);
        step();
        flush = 1'b0;
        iwait = 1'b1;
        imemREN = 1'b0;
        @(negedge clk);
        chk("fl_last_iREN_drop", 32'(iREN), 32'd0);
        step();
        access(32'h500, 1'b0, -1);
        access(32'h504, 1'b1, -1);

        for (int n = 0; n < 250; n++) begin
            int r, way;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_flush($urandom & 32'h1FC);
            end else if (r == 1) begin
                imemREN = 1'b0;
                imemaddr = $urandom;
                @(negedge clk);
                chk("rnd_idle_ihit", 32'(ihit), 32'd0);
                chk("rnd_idle_load", imemload, 32'd0);
                step();
            end else begin
                a = (32'($urandom_range(0, 3)) << 7) |
                    (32'($urandom_range(0, 3)) << 3) |
                    (32'($urandom_range(0, 1)) << 2);
                access(a, m_lookup(a, way), -1);
            end
        end
        @(negedge clk);
        chk("rnd_hit_cnt", hit_cnt, PERF ? 32'(exp_hits) : 32'd0);
        chk("rnd_miss_cnt", miss_cnt, PERF ? 32'(exp_misses) : 32'd0);
        step();

        do_flush(32'h0);
        access(32'h40, 1'b0, -1);
        access(32'h40, 1'b1, -1);
        imemREN = 1'b1;
        imemaddr = 32'h300;
        iwait = 1'b1;
        @(negedge clk);
        chk("rmf_miss", 32'(ihit), 32'd0);
        step();
        @(negedge clk);
        chk("rmf_iREN_fill", 32'(iREN), 32'd1);
        #2;
        rst = 1'b1;
        imemREN = 1'b0;
        #1;
        chk("rmf_iREN_async", 32'(iREN), 32'd0);
        chk("rmf_ihit_async", 32'(ihit), 32'd0);
        chk("rmf_iaddr_async", iaddr, 32'd0);
        step();
        rst = 1'b0;
        m_clear();
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        chk("rmf_hit_cnt", hit_cnt, 32'd0);
        chk("rmf_miss_cnt", miss_cnt, 32'd0);
        step();

        foreach (ptbl[i]) access(ptbl[i].addr, ptbl[i].hit, -1);
        @(negedge clk);
        chk("perf_hit_cnt", hit_cnt, PERF ? 32'd5 : 32'd0);
        chk("perf_miss_cnt", miss_cnt, PERF ? 32'd3 : 32'd0);
        step();

        imemREN4 = 1'b1;
        imemaddr4 = 32'h80;
        iwait4 = 1'b1;
        @(negedge clk);
        chk("bw4_miss", 32'(ihit4), 32'd0);
        step();
        for (int k = 0; k < 2; k++) begin
            iwait4 = 1'b0;
            @(negedge clk);
            chk("bw4_part_addr", iaddr4, 32'h80 + 32'(4 * k));
            step();
        end
        flush4 = 1'b1;
        iwait4 = 1'b1;
        @(negedge clk);
        chk("bw4_flush_iREN", 32'(iREN4), 32'd1);
        step();
        flush4 = 1'b0;
        @(negedge clk);
        chk("bw4_iREN_drop", 32'(iREN4), 32'd0);
        chk("bw4_refetch_miss", 32'(ihit4), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            iwait4 = 1'b0;
            imemaddr4 = $urandom;
            @(negedge clk);
            chk("bw4_fill_addr", iaddr4, 32'h80 + 32'(4 * k));
            chk("bw4_fill_ihit", 32'(ihit4), 32'd0);
            step();
        end
        iwait4 = 1'b1;
        imemaddr4 = 32'h88;
        @(negedge clk);
        chk("bw4_hit", 32'(ihit4), 32'd1);
        chk("bw4_load", imemload4, memf(32'h88));
        chk("bw4_idle_iREN", 32'(iREN4), 32'd0);
        step();
        imemaddr4 = 32'h84;
        @(negedge clk);
        chk("bw4_load_w1", imemload4, memf(32'h84));
        step();
        imemREN4 = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
